// File: rtl/sdc_single_blk_wr_mod.sv
// Single-block SD write engine: streams NWRD 64-bit words onto D0 with a start
// bit, CRC16 and end bit, then collects the card's status token and waits out
// the card's busy indication.
module sdc_single_blk_wr_mod #(
  parameter int unsigned NWRD   = 64,
  parameter logic [15:0] TO_MAX = 16'hFFFF
) (
  input  logic        sdc_clk,
  input  logic        reset,
  input  logic [15:0] command,
  input  logic        strt_strb,
  input  logic [63:0] dat_wrd,
  input  logic        d0_in,
  output logic        d0_out,
  output logic        d0_oe,
  output logic        rd_wrd_strb,
  output logic        tfc,
  output logic        wr_err,
  output logic [2:0]  crc_stat,
  output logic        busy
);

  localparam int unsigned WW = (NWRD > 1) ? $clog2(NWRD) : 1;
  localparam logic [WW-1:0] LastWrd = WW'(NWRD - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StCrc   = 3'd3;
  localparam logic [2:0] StEnd   = 3'd4;
  localparam logic [2:0] StStat  = 3'd5;
  localparam logic [2:0] StBusy  = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [63:0]   sh_q, sh_d;
  logic [15:0]   crc_q, crc_d;
  logic [5:0]    bit_q, bit_d;
  logic [WW-1:0] wrd_q, wrd_d;
  logic [15:0]   to_q, to_d;
  logic          wr_err_q, wr_err_d;
  logic [2:0]    crc_stat_q, crc_stat_d;

  logic        wr_cmd;
  logic        accept;
  logic [15:0] crc_nxt;
  logic        unused_cmd;

  assign unused_cmd = ^{command[15:14], command[7:0]};
  assign wr_cmd     = (command[13:8] == 6'h18) || (command[13:8] == 6'h19);
  assign accept     = (state_q == StIdle) && strt_strb && wr_cmd && !reset;
  // CRC16 (x^16+x^12+x^5+1) advanced by the bit currently on D0.
  assign crc_nxt    = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ sh_q[63]) ? 16'h1021 : 16'h0000);

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    crc_d      = crc_q;
    bit_d      = bit_q;
    wrd_d      = wrd_q;
    to_d       = to_q;
    wr_err_d   = wr_err_q;
    crc_stat_d = crc_stat_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          wr_err_d = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        sh_d    = dat_wrd;
        crc_d   = 16'h0000;
        bit_d   = 6'd0;
        wrd_d   = '0;
        state_d = StData;
      end
      StData: begin
        crc_d = crc_nxt;
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'd63) begin
          // Word fetched at bit 62 is on dat_wrd now.
          sh_d = dat_wrd;
          if (wrd_q == LastWrd) begin
            bit_d   = 6'd0;
            state_d = StCrc;
          end else begin
            wrd_d = wrd_q + WW'(1);
          end
        end else begin
          sh_d = {sh_q[62:0], 1'b0};
        end
      end
      StCrc: begin
        crc_d = {crc_q[14:0], 1'b0};
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'd15) begin
          bit_d   = 6'd0;
          state_d = StEnd;
        end
      end
      StEnd: begin
        to_d    = 16'h0000;
        bit_d   = 6'd0;
        state_d = StStat;
      end
      StStat: begin
        // bit_q: 0 = hunting start bit, 1..3 = token bits, 4 = end bit.
        if (bit_q == 6'd0) begin
          if (!d0_in) begin
            bit_d = 6'd1;
          end else if (to_q == TO_MAX) begin
            wr_err_d = 1'b1;
            state_d  = StDone;
          end else begin
            to_d = to_q + 16'd1;
          end
        end else if (bit_q <= 6'd3) begin
          crc_stat_d = {crc_stat_q[1:0], d0_in};
          bit_d      = bit_q + 6'd1;
        end else begin
          if (crc_stat_q != 3'b010) wr_err_d = 1'b1;
          to_d    = 16'h0000;
          bit_d   = 6'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (d0_in) begin
          state_d = StDone;
        end else if (to_q == TO_MAX) begin
          wr_err_d = 1'b1;
          state_d  = StDone;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        sh_d       = '0;
        crc_d      = '0;
        bit_d      = '0;
        wrd_d      = '0;
        to_d       = '0;
        wr_err_d   = 1'b0;
        crc_stat_d = 3'b000;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge sdc_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      crc_q      <= '0;
      bit_q      <= '0;
      wrd_q      <= '0;
      to_q       <= '0;
      wr_err_q   <= 1'b0;
      crc_stat_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      crc_q      <= crc_d;
      bit_q      <= bit_d;
      wrd_q      <= wrd_d;
      to_q       <= to_d;
      wr_err_q   <= wr_err_d;
      crc_stat_q <= crc_stat_d;
    end
  end

  // Line drive, fetch strobe and completion pulse decoded from the state.
  always_comb begin
    d0_out      = 1'b1;
    d0_oe       = 1'b0;
    rd_wrd_strb = 1'b0;
    tfc         = 1'b0;
    case (state_q)
      StIdle:  rd_wrd_strb = accept;
      StStart: begin
        d0_oe  = 1'b1;
        d0_out = 1'b0;
      end
      StData: begin
        d0_oe       = 1'b1;
        d0_out      = sh_q[63];
        rd_wrd_strb = (bit_q == 6'd62) && (wrd_q != LastWrd);
      end
      StCrc: begin
        d0_oe  = 1'b1;
        d0_out = crc_q[15];
      end
      StEnd:   d0_oe = 1'b1;
      StDone:  tfc = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign wr_err   = wr_err_q;
  assign crc_stat = crc_stat_q;

endmodule

// File: tb/tb_sdc_single_blk_wr_mod.sv
// Bench for sdc_single_blk_wr_mod: a cycle-indexed block model derived from
// the block timeline, plus directed checks on counts, CRC and timeouts.
module tb_sdc_single_blk_wr_mod;

  localparam int unsigned NWRD   = 64;
  localparam logic [15:0] TO_MAX = 16'h0100;
  // Cycle index k within a block; k = 0 is the accept cycle.
  localparam int KDataLo = 2;
  localparam int KDataHi = 1 + 64 * 64;
  localparam int KCrcHi  = KDataHi + 16;
  localparam int KEnd    = KCrcHi + 1;
  localparam int KStat   = KEnd + 1;
  localparam int ToLen   = 257;

  logic        sdc_clk;
  logic        reset;
  logic [15:0] command;
  logic        strt_strb;
  logic [63:0] dat_wrd;
  logic        d0_in;
  logic        d0_out;
  logic        d0_oe;
  logic        rd_wrd_strb;
  logic        tfc;
  logic        wr_err;
  logic [2:0]  crc_stat;
  logic        busy;

  sdc_single_blk_wr_mod #(.NWRD(NWRD), .TO_MAX(TO_MAX)) dut (
    .sdc_clk    (sdc_clk),
    .reset      (reset),
    .command    (command),
    .strt_strb  (strt_strb),
    .dat_wrd    (dat_wrd),
    .d0_in      (d0_in),
    .d0_out     (d0_out),
    .d0_oe      (d0_oe),
    .rd_wrd_strb(rd_wrd_strb),
    .tfc        (tfc),
    .wr_err     (wr_err),
    .crc_stat   (crc_stat),
    .busy       (busy)
  );

  initial sdc_clk = 1'b0;
  always #5 sdc_clk = ~sdc_clk;

  logic [63:0] mem [64];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  // Stimulus-side block script (card behaviour).
  int cur_tok_dly, cur_busy_len;
  logic [2:0] cur_tok;

  // Model state.
  logic in_blk = 1'b0;
  int k = 0;
  int m_tok_dly, m_B, m_D;
  logic [2:0] m_tok;
  logic m_tok_bad, m_timeout;
  logic [15:0] m_crc;
  logic m_err = 1'b0;
  logic [2:0] m_stat = 3'b000;

  // Monitors.
  int tot_oe = 0, tot_rd = 0, tot_tfc = 0, stat_cyc = 0, tfc_cyc = 0;
  logic [63:0] ser_hist = '0;
  logic prev_oe_n = 1'b0, prev_oe_p = 1'b0, rd_seen = 1'b0;
  int ptr = 0;
  int card_pos = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] crc_mem();
    logic [15:0] c = 16'h0000;
    for (int w = 0; w < 64; w++)
      for (int b = 63; b >= 0; b--) c = crc_bit(c, mem[w][b]);
    return c;
  endfunction

  // Expected {oe,out,rd,tfc,busy,wr_err,crc_stat} at block cycle kk.
  function automatic logic [8:0] exp_vec(input int kk);
    logic oe, out, rd, tf, er;
    logic [2:0] st;
    int i, w, b, t;
    oe  = (kk >= 1) && (kk <= KEnd);
    out = 1'b1;
    rd  = 1'b0;
    if (kk == 1) out = 1'b0;
    else if (kk >= KDataLo && kk <= KDataHi) begin
      i = kk - KDataLo;
      w = i / 64;
      b = i % 64;
      out = mem[w][63 - b];
      rd = (b == 62) && (w < 63);
    end else if (kk > KDataHi && kk <= KCrcHi) out = m_crc[15 - (kk - KDataHi - 1)];
    tf = (kk == m_D);
    er = (m_timeout && kk >= m_D) || (m_tok_bad && kk >= m_B);
    if (m_tok_dly < 0) st = m_stat;
    else begin
      t = KStat + m_tok_dly;
      if (kk <= t + 1) st = m_stat;
      else if (kk == t + 2) st = {m_stat[1:0], m_tok[2]};
      else if (kk == t + 3) st = {m_stat[0], m_tok[2:1]};
      else st = m_tok;
    end
    return {oe, out, rd, tf, 1'b1, er, st};
  endfunction

  // Card D0 level at position p after the host releases the line.
  function automatic logic card_bit(input int p);
    int q;
    if (cur_tok_dly < 0 || p < cur_tok_dly) return 1'b1;
    q = p - cur_tok_dly;
    if (q == 0) return 1'b0;
    if (q == 1) return cur_tok[2];
    if (q == 2) return cur_tok[1];
    if (q == 3) return cur_tok[0];
    if (q == 4) return 1'b1;
    if (q - 5 < cur_busy_len) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: compare at negedge, then drive bram/card just after posedge.
  task automatic tick();
    logic [8:0] got, exp, fin;
    logic acc;
    @(negedge sdc_clk);
    cyc++;
    got = {d0_oe, d0_out, rd_wrd_strb, tfc, busy, wr_err, crc_stat};
    acc = 1'b0;
    if (in_blk) exp = exp_vec(k);
    else begin
      acc = !reset && strt_strb && (command[13:8] == 6'h18 || command[13:8] == 6'h19);
      exp = {1'b0, 1'b1, acc, 1'b0, 1'b0, m_err, m_stat};
    end
    if (chk_en) begin
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL cycle_cmp cyc %0d k %0d: got %b expected %b", cyc, k, got, exp);
    end
    if (d0_oe) begin
      tot_oe++;
      ser_hist = {ser_hist[62:0], d0_out};
    end
    if (prev_oe_n && !d0_oe) stat_cyc = cyc;
    prev_oe_n = d0_oe;
    rd_seen = rd_wrd_strb;
    if (rd_wrd_strb) tot_rd++;
    if (tfc) begin
      tot_tfc++;
      tfc_cyc = cyc;
    end
    if (reset) begin
      in_blk = 1'b0;
      m_err  = 1'b0;
      m_stat = 3'b000;
    end else if (in_blk) begin
      if (k == m_D) begin
        fin = exp_vec(k);
        m_err  = fin[3];
        m_stat = fin[2:0];
        in_blk = 1'b0;
      end else k++;
    end else if (acc) begin
      m_tok_dly = cur_tok_dly;
      m_tok     = cur_tok;
      m_crc     = crc_mem();
      if (cur_tok_dly < 0) begin
        m_timeout = 1'b1;
        m_tok_bad = 1'b0;
        m_B = 0;
        m_D = KStat + ToLen;
      end else begin
        m_B = KStat + cur_tok_dly + 5;
        m_tok_bad = (cur_tok != 3'b010);
        m_timeout = (cur_busy_len >= ToLen);
        m_D = m_timeout ? m_B + ToLen : m_B + cur_busy_len + 1;
      end
      in_blk = 1'b1;
      k = 1;
    end
    @(posedge sdc_clk);
    #1;
    if (rd_seen) begin
      dat_wrd = mem[ptr % 64];
      ptr++;
    end
    if (reset) begin
      card_pos = -1;
      d0_in = 1'b1;
    end else begin
      if (prev_oe_p && !d0_oe) card_pos = 0;
      if (card_pos >= 0) begin
        d0_in = card_bit(card_pos);
        card_pos++;
        if (card_pos > 2000) card_pos = -1;
      end
    end
    prev_oe_p = d0_oe;
  endtask

  task automatic run_block(input logic [15:0] cmd, input int tok_dly, input logic [2:0] tok,
                           input int busy_len, input int stb_at,
                           output int d_oe, output int d_rd, output int d_tfc);
    int oe0, rd0, tfc0;
    logic done_ok;
    oe0 = tot_oe;
    rd0 = tot_rd;
    tfc0 = tot_tfc;
    cur_tok_dly = tok_dly;
    cur_tok = tok;
    cur_busy_len = busy_len;
    ptr = 0;
    command = cmd;
    strt_strb = 1'b1;
    tick();
    strt_strb = 1'b0;
    done_ok = 1'b0;
    for (int j = 0; j < 6000 && !done_ok; j++) begin
      if (j == stb_at) strt_strb = 1'b1;
      tick();
      strt_strb = 1'b0;
      if (tot_tfc != tfc0) done_ok = 1'b1;
    end
    check("blk_done_in_budget", 32'(done_ok), 32'd1);
    tick();
    tick();
    d_oe = tot_oe - oe0;
    d_rd = tot_rd - rd0;
    d_tfc = tot_tfc - tfc0;
  endtask

  initial begin
    logic [71:0] msg;
    logic [15:0] c;
    int d_oe, d_rd, d_tfc, rd0;
    reset = 1'b1;
    command = 16'h0000;
    strt_strb = 1'b0;
    dat_wrd = '0;
    d0_in = 1'b1;

    // Pin the CRC model against well-known values.
    msg = "123456789";
    c = 16'h0000;
    for (int j = 0; j < 9; j++)
      for (int b = 7; b >= 0; b--) c = crc_bit(c, msg[71 - 8 * j - (7 - b)]);
    check("crc_model_123456789", 32'(c), 32'h31C3);
    for (int w = 0; w < 64; w++) mem[w] = '1;
    check("crc_model_all_ff", 32'(crc_mem()), 32'h7FA1);

    tick();
    tick();
    chk_en = 1'b1;
    check("reset_outputs", 32'({d0_oe, d0_out, rd_wrd_strb, tfc, busy, wr_err, crc_stat}),
          32'h080);
    reset = 1'b0;
    tick();

    // Nominal CMD24 block with a stray strobe mid-DATA.
    for (int w = 0; w < 64; w++) mem[w] = 64'h0123_4567_89AB_CDEF + 64'(w);
    run_block(16'h1800, 3, 3'b010, 20, 100, d_oe, d_rd, d_tfc);
    check("nom_oe_cycles", 32'(d_oe), 32'd4114);
    check("nom_rd_pulses", 32'(d_rd), 32'd64);
    check("nom_tfc_pulses", 32'(d_tfc), 32'd1);
    check("nom_wr_err", 32'(wr_err), 32'd0);
    check("nom_crc_stat", 32'(crc_stat), 32'd2);
    check("nom_crc_bits", 32'(ser_hist[16:1]), 32'(crc_mem()));
    check("nom_end_bit", 32'(ser_hist[0]), 32'd1);

    // All-zero block, card reports CRC error.
    for (int w = 0; w < 64; w++) mem[w] = '0;
    run_block(16'h1800, 1, 3'b101, 10, -1, d_oe, d_rd, d_tfc);
    check("zero_crc_bits", 32'(ser_hist[16:1]), 32'h0000);
    check("zero_crc_stat", 32'(crc_stat), 32'd5);
    check("zero_wr_err", 32'(wr_err), 32'd1);
    check("zero_tfc_pulses", 32'(d_tfc), 32'd1);

    // Non-write command is ignored.
    rd0 = tot_rd;
    command = 16'h1100;
    strt_strb = 1'b1;
    tick();
    strt_strb = 1'b0;
    repeat (3) tick();
    check("ign_busy", 32'(busy), 32'd0);
    check("ign_oe", 32'(d0_oe), 32'd0);
    check("ign_rd", 32'(tot_rd - rd0), 32'd0);

    // No status token: timeout in STAT.
    run_block(16'h1800, -1, 3'b010, 0, -1, d_oe, d_rd, d_tfc);
    check("stat_to_wr_err", 32'(wr_err), 32'd1);
    check("stat_to_tfc", 32'(d_tfc), 32'd1);
    check("stat_to_latency", 32'((tfc_cyc - stat_cyc >= 256) && (tfc_cyc - stat_cyc <= 258)),
          32'd1);
    check("stat_to_crc_stat", 32'(crc_stat), 32'd5);

    // Reset at word 10, bit 30.
    for (int w = 0; w < 64; w++) mem[w] = 64'h0123_4567_89AB_CDEF + 64'(w);
    cur_tok_dly = 3;
    cur_tok = 3'b010;
    cur_busy_len = 20;
    ptr = 0;
    command = 16'h1800;
    strt_strb = 1'b1;
    tick();
    strt_strb = 1'b0;
    repeat (671) tick();
    check("pre_reset_oe", 32'(d0_oe), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_oe", 32'(d0_oe), 32'd0);
    check("post_reset_out", 32'(d0_out), 32'd1);
    tick();
    run_block(16'h1900, 2, 3'b010, 5, -1, d_oe, d_rd, d_tfc);
    check("fresh_oe_cycles", 32'(d_oe), 32'd4114);
    check("fresh_rd_pulses", 32'(d_rd), 32'd64);
    check("fresh_tfc_pulses", 32'(d_tfc), 32'd1);
    check("fresh_wr_err", 32'(wr_err), 32'd0);
    check("fresh_crc_bits", 32'(ser_hist[16:1]), 32'(crc_mem()));

    // Card stays busy past the timeout.
    run_block(16'h1800, 2, 3'b010, 300, -1, d_oe, d_rd, d_tfc);
    check("busy_to_wr_err", 32'(wr_err), 32'd1);
    check("busy_to_tfc", 32'(d_tfc), 32'd1);
    check("busy_to_crc_stat", 32'(crc_stat), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdc_single_blk_wr_mod.md
SDC_SINGLE_BLK_WR_MOD -- requirements
Module: sdc_single_blk_wr_mod

Interface
REQ-001 SHALL have parameter NWRD, default 64: number of 64-bit words per block (512 bytes).
REQ-002 SHALL have parameter TO_MAX, default 16'hFFFF: timeout limit, in sdc_clk cycles, for the status-token wait and the busy wait.
REQ-003 SHALL have port sdc_clk, input, 1: sd card clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port command, input, 16: current command; command[13:8] = 6'h18 (CMD24) or 6'h19 (CMD25) qualifies a write.
REQ-006 SHALL have port strt_strb, input, 1: one-cycle request to transmit one block.
REQ-007 SHALL have port dat_wrd, input, 64: word from the data bram, valid the cycle after rd_wrd_strb.
REQ-008 SHALL have port d0_in, input, 1: sd card D0, sampled for the status token and busy.
REQ-009 SHALL have port d0_out, output, 1: serial data driven onto D0.
REQ-010 SHALL have port d0_oe, output, 1: D0 output enable; 1 = module drives D0.
REQ-011 SHALL have port rd_wrd_strb, output, 1: one-cycle fetch request to the data bram.
REQ-012 SHALL have port tfc, output, 1: one-cycle pulse; the block transfer is complete.
REQ-013 SHALL have port wr_err, output, 1: sticky error flag for the last block (bad token or timeout); cleared on the next accepted strt_strb.
REQ-014 SHALL have port crc_stat, output, 3: last received status-token bits.
REQ-015 SHALL have port busy, output, 1: high while in any state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, START, DATA, CRC, END, STAT, BUSY and DONE.
REQ-017 IDLE SHALL accept strt_strb only if command qualifies; in the accept cycle it SHALL pulse rd_wrd_strb and clear wr_err; next state START.
- Any other strt_strb SHALL be ignored.
- strt_strb outside IDLE SHALL be ignored.
REQ-018 START (1 cycle) SHALL do the following, then go to DATA:
- d0_oe=1, d0_out=0;
- load dat_wrd into the 64-bit shift register;
- clear the CRC16 and the bit/word counters.
REQ-019 DATA SHALL last exactly NWRD*64 cycles (4096 at default), with d0_out = shift-register bit 63 (MSB first) and a left shift every cycle.
REQ-020 In DATA, rd_wrd_strb SHALL pulse in the cycle where bit index = 62 of words 0..NWRD-2 only, giving NWRD pulses total including the accept pulse.
- At bit index 63, dat_wrd SHALL be loaded into the shift register for the next cycle.
REQ-021 The CRC16 SHALL be updated each DATA cycle with d0_out.
- Polynomial: x^16+x^12+x^5+1.
- Initial value: 0.
REQ-022 CRC (16 cycles) SHALL shift the CRC16 out MSB first on d0_out, with d0_oe=1.
REQ-023 END (1 cycle) SHALL drive d0_out=1, d0_oe=1; next state STAT.
REQ-024 STAT SHALL drive d0_oe=0 and d0_out=1 and wait for d0_in=0 (token start bit).
- It SHALL then shift the next 3 d0_in bits into crc_stat (MSB first) and skip the end bit.
- Next state: BUSY.
REQ-025 crc_stat = 3'b010 SHALL be accepted.
- Any other value (3'b101 = card CRC error) SHALL set wr_err.
- The state machine SHALL still proceed to BUSY.
REQ-026 BUSY SHALL wait for d0_in=1, then go to DONE.
REQ-027 A 16-bit timeout counter SHALL:
- clear on entry to STAT and on entry to BUSY;
- increment while waiting for the token start bit (STAT) or for d0_in=1 (BUSY);
- on reaching TO_MAX, set wr_err and go to DONE.
REQ-028 DONE (1 cycle) SHALL pulse tfc=1 and return to IDLE; tfc SHALL be 0 in all other states.
REQ-029 d0_oe SHALL be 1 only in START, DATA, CRC and END.
- Total drive time per block = 1+4096+16+1 = 4114 cycles at default NWRD.
REQ-030 An illegal or unreachable state encoding SHALL recover to IDLE with all outputs at reset values.

Reset
REQ-031 reset SHALL take precedence over all other inputs in any state, including mid-DATA and mid-BUSY.
REQ-032 On reset, the block SHALL return to IDLE in the next cycle with outputs as follows:
- d0_out=1;
- d0_oe=0;
- rd_wrd_strb=0;
- tfc=0;
- wr_err=0;
- crc_stat=3'b000;
- busy=0.
REQ-033 On reset, the shift register, the CRC16 and all counters SHALL be cleared.

Verification
REQ-034 Bench SHALL run a nominal CMD24 block: 64 words of pattern 64'h0123_4567_89AB_CDEF + n, card returns token 010, then 20 busy cycles.
- Required: d0_oe high for 4114 cycles.
- Required: a start bit, the data MSB-first and a CRC16 matching a reference model.
- Required: end bit=1, exactly 64 rd_wrd_strb pulses, one tfc pulse, wr_err=0.
REQ-035 Bench SHALL send an all-zero block followed by token 101.
- Required: CRC bits 16'h0000, crc_stat=3'b101, wr_err=1, tfc pulsed once.
REQ-036 Bench SHALL send a strt_strb with command[13:8]=6'h11.
- Required: no state change, d0_oe=0, no rd_wrd_strb.
REQ-037 Bench SHALL hold d0_in=1 after END, with TO_MAX=16'h0100.
- Required: wr_err=1 and tfc pulse 257 cycles after STAT entry (±1).
REQ-038 Bench SHALL assert reset at data word 10, bit 30.
- Required: next cycle shows IDLE, d0_oe=0, busy=0.
- Required: a fresh strt_strb then produces a full correct block.
REQ-039 Bench SHALL hold d0_in=0 (busy) for TO_MAX cycles after the token.
- Required: timeout sets wr_err=1 and tfc pulses.
